// File: rtl/ddr_rw_arbiter_pkg.sv
// ddr_rw_arbiter_pkg: shared types and constants for the DDR read/write arbiter
package ddr_rw_arbiter_pkg;
    localparam int ADDR_WIDTH     = 25;
    localparam int DATA_WIDTH     = 512;
    localparam int PDU_ADDR_SHIFT = 5;

    typedef enum logic [1:0] {ARB_IDLE, WR_BURST, RD_BURST} arb_state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } ddr_cmd_t;

    function automatic logic [ADDR_WIDTH-1:0] pdu_base(input logic [ADDR_WIDTH-1:0] pdu_id);
        return pdu_id << PDU_ADDR_SHIFT;
    endfunction
endpackage

// File: rtl/ddr_rw_arbiter_if.sv
// ddr_rw_arbiter_if: PDU write/read streams, DRAM command port and credit status
interface ddr_rw_arbiter_if import ddr_rw_arbiter_pkg::*; #(parameter int CNT_W = 7);
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_sop;
    logic                  wr_eop;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_sop;
    logic                  rd_eop;
    logic                  rd_valid;
    logic                  rd_ready;
    logic                  ddr_cmd_write;
    logic [ADDR_WIDTH-1:0] ddr_cmd_addr;
    logic [DATA_WIDTH-1:0] ddr_cmd_wdata;
    logic                  ddr_cmd_valid;
    logic                  ddr_cmd_ready;
    logic                  ddr_rd_resp_fire;
    logic [CNT_W-1:0]      rd_outstanding;
    logic                  proto_err;

    modport master (
        output wr_addr, wr_data, wr_sop, wr_eop, wr_valid,
        output rd_addr, rd_sop, rd_eop, rd_valid,
        output ddr_cmd_ready, ddr_rd_resp_fire,
        input  wr_ready, rd_ready, ddr_cmd_write, ddr_cmd_addr, ddr_cmd_wdata, ddr_cmd_valid,
        input  rd_outstanding, proto_err
    );

    modport slave (
        input  wr_addr, wr_data, wr_sop, wr_eop, wr_valid,
        input  rd_addr, rd_sop, rd_eop, rd_valid,
        input  ddr_cmd_ready, ddr_rd_resp_fire,
        output wr_ready, rd_ready, ddr_cmd_write, ddr_cmd_addr, ddr_cmd_wdata, ddr_cmd_valid,
        output rd_outstanding, proto_err
    );
endinterface

// File: rtl/ddr_rw_arbiter.sv
// ddr_rw_arbiter: PDU-granular round-robin arbiter sharing one DRAM command port
module ddr_rw_arbiter import ddr_rw_arbiter_pkg::*; #(
    parameter int MAX_RD_OUTSTANDING = 64
) (
    input logic clk,
    input logic rst,
    ddr_rw_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_RD_OUTSTANDING + 1);

    arb_state_t       state_q, state_d;
    logic             last_q, last_d;
    ddr_cmd_t         cmd_q, cmd_d;
    logic             cmd_valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             mid_q;

    logic slot_free, credit_ok, wr_head, rd_head, wr_drop, rd_drop;
    logic wr_go, rd_go, go, sop, eop;

    assign slot_free = !cmd_valid_q | bus.ddr_cmd_ready;
    assign credit_ok = cnt_q < CNT_W'(MAX_RD_OUTSTANDING);
    assign wr_head   = bus.wr_valid & bus.wr_sop;
    assign rd_head   = bus.rd_valid & bus.rd_sop & credit_ok;
    assign wr_drop   = (state_q == ARB_IDLE) & bus.wr_valid & !bus.wr_sop;
    assign rd_drop   = (state_q == ARB_IDLE) & bus.rd_valid & !bus.rd_sop & !wr_drop;
    assign wr_go     = (state_q == WR_BURST) & bus.wr_valid & slot_free;
    assign rd_go     = (state_q == RD_BURST) & bus.rd_valid & slot_free & credit_ok;
    assign go        = wr_go | rd_go;
    assign sop       = wr_go ? bus.wr_sop : bus.rd_sop;
    assign eop       = wr_go ? bus.wr_eop : bus.rd_eop;

    assign bus.wr_ready       = wr_drop | ((state_q == WR_BURST) & slot_free);
    assign bus.rd_ready       = rd_drop | ((state_q == RD_BURST) & slot_free & credit_ok);
    assign bus.ddr_cmd_write  = cmd_q.write;
    assign bus.ddr_cmd_addr   = cmd_q.addr;
    assign bus.ddr_cmd_wdata  = cmd_q.wdata;
    assign bus.ddr_cmd_valid  = cmd_valid_q;
    assign bus.rd_outstanding = cnt_q;
    assign bus.proto_err      = err_q;

    assign cmd_d = '{write: wr_go, addr: wr_go ? bus.wr_addr : bus.rd_addr, wdata: bus.wr_data};

    // eop hands off to the other side first so neither stream can starve the other
    always_comb begin
        last_d  = (wr_go & eop) ? 1'b0 : (rd_go & eop) ? 1'b1 : last_q;
        state_d = state_q;
        if (state_q == ARB_IDLE)
            state_d = (wr_head & rd_head) ? (last_q ? WR_BURST : RD_BURST) :
                      wr_head ? WR_BURST : rd_head ? RD_BURST : ARB_IDLE;
        else if (go & eop)
            state_d = (wr_go ? rd_head : wr_head) ? (wr_go ? RD_BURST : WR_BURST) :
                      (wr_go ? wr_head : rd_head) ? state_q : ARB_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            last_q      <= 1'b1;
            cmd_valid_q <= 1'b0;
            cmd_q.write <= 1'b0;
            cmd_q.addr  <= '0;
            err_q       <= 1'b0;
            mid_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cmd_valid_q <= go | (cmd_valid_q & !bus.ddr_cmd_ready);
            err_q       <= err_q | wr_drop | rd_drop | (go & sop & mid_q);
            if (go) begin
                cmd_q <= cmd_d;
                mid_q <= !eop;
            end
        end
    end

    // stale responses after reset must not wrap the counter below zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + CNT_W'(rd_go) - CNT_W'(bus.ddr_rd_resp_fire & ((cnt_q != '0) | rd_go));
    end
endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// tb_ddr_rw_arbiter: directed self-checking bench for the DDR read/write arbiter
module tb_ddr_rw_arbiter;
    import ddr_rw_arbiter_pkg::*;

    localparam int MAXR = 4;
    localparam int CW   = $clog2(MAXR + 1);

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  sop;
        logic                  eop;
    } flit_t;

    typedef struct {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        int                    cyc;
    } cap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddr_rw_arbiter_if #(.CNT_W(CW)) bus();
    ddr_rw_arbiter #(.MAX_RD_OUTSTANDING(MAXR)) dut (.clk(clk), .rst(rst), .bus(bus));

    flit_t                 wq[$];
    flit_t                 rq[$];
    cap_t                  cap[$];
    logic [ADDR_WIDTH:0]   exp_q[$];
    int                    cyc;
    int                    checks;
    int                    failures;

    function automatic logic [DATA_WIDTH-1:0] dpat(input logic [ADDR_WIDTH-1:0] a);
        return {16{7'h2B, a}};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DATA_WIDTH-1:0] obs, input logic [DATA_WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit wr, input logic [ADDR_WIDTH-1:0] base, input int n, input int mid_sop, input bit first_sop);
        for (int i = 0; i < n; i++) begin
            flit_t f;
            f.addr = base + ADDR_WIDTH'(i);
            f.data = dpat(f.addr);
            f.sop  = (i == 0 && first_sop) || i == mid_sop;
            f.eop  = i == n - 1;
            if (wr) wq.push_back(f);
            else rq.push_back(f);
        end
    endtask

    task automatic drive();
        bus.wr_valid = wq.size() != 0;
        bus.wr_addr  = wq.size() != 0 ? wq[0].addr : '0;
        bus.wr_data  = wq.size() != 0 ? wq[0].data : '0;
        bus.wr_sop   = wq.size() != 0 ? wq[0].sop : 1'b0;
        bus.wr_eop   = wq.size() != 0 ? wq[0].eop : 1'b0;
        bus.rd_valid = rq.size() != 0;
        bus.rd_addr  = rq.size() != 0 ? rq[0].addr : '0;
        bus.rd_sop   = rq.size() != 0 ? rq[0].sop : 1'b0;
        bus.rd_eop   = rq.size() != 0 ? rq[0].eop : 1'b0;
    endtask

    task automatic tick();
        bit wf, rf;
        @(posedge clk);
        wf = bus.wr_valid && bus.wr_ready;
        rf = bus.rd_valid && bus.rd_ready;
        if (bus.ddr_cmd_valid && bus.ddr_cmd_ready)
            cap.push_back('{bus.ddr_cmd_write, bus.ddr_cmd_addr, bus.ddr_cmd_wdata, cyc});
        cyc++;
        #1;
        if (wf && wq.size() != 0) void'(wq.pop_front());
        if (rf && rq.size() != 0) void'(rq.pop_front());
        drive();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && !(wq.size() == 0 && rq.size() == 0 && !bus.ddr_cmd_valid); i++) tick();
        chk(tag, 64'(wq.size() == 0 && rq.size() == 0 && !bus.ddr_cmd_valid), 64'(1));
    endtask

    function automatic void ex(input bit w, input logic [ADDR_WIDTH-1:0] a);
        exp_q.push_back({w, a});
    endfunction

    task automatic chk_cap(input string tag);
        chk({tag, "_count"}, 64'(cap.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < cap.size()) begin
                chk($sformatf("%s_cmd%0d", tag, i), 64'({cap[i].write, cap[i].addr}), 64'(exp_q[i]));
                if (exp_q[i][ADDR_WIDTH])
                    chkd($sformatf("%s_wdata%0d", tag, i), cap[i].wdata, dpat(exp_q[i][ADDR_WIDTH-1:0]));
            end
        end
        cap.delete();
        exp_q.delete();
    endtask

    task automatic reset_start();
        rst = 1'b1;
        wq.delete();
        rq.delete();
        drive();
        bus.ddr_rd_resp_fire = 1'b0;
        bus.ddr_cmd_ready    = 1'b1;
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_wr_ready"}, 64'(bus.wr_ready), 64'(0));
        chk({tag, "_rd_ready"}, 64'(bus.rd_ready), 64'(0));
        chk({tag, "_cmd_valid"}, 64'(bus.ddr_cmd_valid), 64'(0));
        chk({tag, "_cmd_write"}, 64'(bus.ddr_cmd_write), 64'(0));
        chk({tag, "_cmd_addr"}, 64'(bus.ddr_cmd_addr), 64'(0));
        chk({tag, "_rd_out"}, 64'(bus.rd_outstanding), 64'(0));
        chk({tag, "_proto_err"}, 64'(bus.proto_err), 64'(0));
    endtask

    initial begin
        logic                  pv, pr, pw;
        logic [ADDR_WIDTH-1:0] pa;
        logic [DATA_WIDTH-1:0] pd;
        cyc = 0;
        checks = 0;
        failures = 0;

        // reset state
        reset_start();
        tick();
        tick();
        chk_reset("rst");
        rst = 1'b0;
        tick();

        // single 3-flit write PDU at 0x40, one bubble from idle
        push(1'b1, pdu_base(2), 3, -1, 1'b1);
        drive();
        tick();
        chk("t1_bubble_valid", 64'(bus.ddr_cmd_valid), 64'(0));
        chk("t1_wr_ready", 64'(bus.wr_ready), 64'(1));
        tick();
        chk("t1_first_valid", 64'(bus.ddr_cmd_valid), 64'(1));
        chk("t1_first_addr", 64'(bus.ddr_cmd_addr), 64'h40);
        chk("t1_first_write", 64'(bus.ddr_cmd_write), 64'(1));
        chkd("t1_first_wdata", bus.ddr_cmd_wdata, dpat(25'h40));
        drain("t1_drain");
        ex(1'b1, 25'h40); ex(1'b1, 25'h41); ex(1'b1, 25'h42);
        chk_cap("t1");

        // write and read present together from reset: write first, no handoff bubble
        reset_start();
        tick();
        tick();
        rst = 1'b0;
        cap.delete();
        push(1'b1, 25'h80, 2, -1, 1'b1);
        push(1'b0, 25'hA0, 2, -1, 1'b1);
        drive();
        drain("t2_drain");
        chk("t2_span", 64'(cap.size() == 4 ? cap[3].cyc - cap[0].cyc : -1), 64'(3));
        ex(1'b1, 25'h80); ex(1'b1, 25'h81); ex(1'b0, 25'hA0); ex(1'b0, 25'hA1);
        chk_cap("t2");
        chk("t2_rd_out", 64'(bus.rd_outstanding), 64'(2));
        bus.ddr_rd_resp_fire = 1'b1;
        tick();
        tick();
        bus.ddr_rd_resp_fire = 1'b0;
        chk("t2_rd_out_clr", 64'(bus.rd_outstanding), 64'(0));

        // credit exhaustion stalls a 6-flit read PDU at 4 outstanding
        push(1'b0, 25'hC0, 6, -1, 1'b1);
        drive();
        repeat (15) tick();
        chk("t3_issued", 64'(cap.size()), 64'(4));
        chk("t3_rd_out_full", 64'(bus.rd_outstanding), 64'(4));
        chk("t3_rd_ready_stall", 64'(bus.rd_ready), 64'(0));
        chk("t3_pending", 64'(rq.size()), 64'(2));
        bus.ddr_rd_resp_fire = 1'b1;
        tick();
        tick();
        bus.ddr_rd_resp_fire = 1'b0;
        drain("t3_drain");
        chk("t3_rd_out_end", 64'(bus.rd_outstanding), 64'(4));
        ex(1'b0, 25'hC0); ex(1'b0, 25'hC1); ex(1'b0, 25'hC2);
        ex(1'b0, 25'hC3); ex(1'b0, 25'hC4); ex(1'b0, 25'hC5);
        chk_cap("t3");
        bus.ddr_rd_resp_fire = 1'b1;
        repeat (5) tick();
        bus.ddr_rd_resp_fire = 1'b0;
        chk("t3_rd_out_sat", 64'(bus.rd_outstanding), 64'(0));

        // ddr_cmd_ready toggling during a 4-flit write
        push(1'b1, 25'h100, 4, -1, 1'b1);
        drive();
        for (int i = 0; i < 16; i++) begin
            bus.ddr_cmd_ready = i[0];
            #1;
            if (bus.ddr_cmd_valid && !bus.ddr_cmd_ready)
                chk("t4_wr_ready_low", 64'(bus.wr_ready), 64'(0));
            pv = bus.ddr_cmd_valid;
            pr = bus.ddr_cmd_ready;
            pw = bus.ddr_cmd_write;
            pa = bus.ddr_cmd_addr;
            pd = bus.ddr_cmd_wdata;
            tick();
            if (pv && !pr) begin
                chk("t4_hold_valid", 64'(bus.ddr_cmd_valid), 64'(1));
                chk("t4_hold_addr", 64'(bus.ddr_cmd_addr), 64'(pa));
                chk("t4_hold_write", 64'(bus.ddr_cmd_write), 64'(pw));
                chkd("t4_hold_wdata", bus.ddr_cmd_wdata, pd);
            end
        end
        bus.ddr_cmd_ready = 1'b1;
        drain("t4_drain");
        ex(1'b1, 25'h100); ex(1'b1, 25'h101); ex(1'b1, 25'h102); ex(1'b1, 25'h103);
        chk_cap("t4");

        // non-sop head in idle is dropped and flags a protocol error
        chk("t5_err_before", 64'(bus.proto_err), 64'(0));
        push(1'b1, 25'h1FF, 1, -1, 1'b0);
        drive();
        #1;
        chk("t5_drop_ready", 64'(bus.wr_ready), 64'(1));
        tick();
        chk("t5_err_set", 64'(bus.proto_err), 64'(1));
        chk("t5_dropped", 64'(wq.size()), 64'(0));
        repeat (3) tick();
        chk("t5_no_cmd", 64'(cap.size()), 64'(0));
        push(1'b1, 25'h180, 2, -1, 1'b1);
        drive();
        drain("t5_drain");
        ex(1'b1, 25'h180); ex(1'b1, 25'h181);
        chk_cap("t5");
        chk("t5_err_sticky", 64'(bus.proto_err), 64'(1));

        // tie after a write burst goes to read
        push(1'b1, 25'h1C0, 2, -1, 1'b1);
        push(1'b0, 25'h1E0, 2, -1, 1'b1);
        drive();
        drain("t7_drain");
        ex(1'b0, 25'h1E0); ex(1'b0, 25'h1E1); ex(1'b1, 25'h1C0); ex(1'b1, 25'h1C1);
        chk_cap("t7");
        bus.ddr_rd_resp_fire = 1'b1;
        tick();
        tick();
        bus.ddr_rd_resp_fire = 1'b0;
        chk("t7_rd_out_clr", 64'(bus.rd_outstanding), 64'(0));

        // reset during flit 2 of a 4-flit read PDU
        push(1'b0, 25'h140, 4, -1, 1'b1);
        drive();
        tick();
        tick();
        tick();
        chk("t6_rd_out_mid", 64'(bus.rd_outstanding), 64'(2));
        chk("t6_valid_mid", 64'(bus.ddr_cmd_valid), 64'(1));
        reset_start();
        chk_reset("t6_rst");
        tick();
        rst = 1'b0;
        bus.ddr_rd_resp_fire = 1'b1;
        tick();
        bus.ddr_rd_resp_fire = 1'b0;
        chk("t6_stale_fire", 64'(bus.rd_outstanding), 64'(0));
        chk("t6_idle_valid", 64'(bus.ddr_cmd_valid), 64'(0));
        cap.delete();

        // sop seen mid-burst is forwarded and flags a protocol error
        push(1'b1, 25'h160, 3, 1, 1'b1);
        drive();
        drain("t8_drain");
        ex(1'b1, 25'h160); ex(1'b1, 25'h161); ex(1'b1, 25'h162);
        chk_cap("t8");
        chk("t8_err", 64'(bus.proto_err), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
